// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial adder sequencer around a single full-adder cell and a carry
// flip-flop. Operands arrive over a valid/ready handshake, are added one bit
// per clock LSB first, and the result is offered over a second valid/ready
// handshake.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, an extra input 'sub' selects a-b (two's complement: ~b and
//   initial carry 1, cin ignored). cout=1 then means "no borrow".
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand bundle valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       WIDTH-bit operands
//   cin        initial carry-in
//   sub        (SERIAL_ADDER_SUB_EN only) subtract select
//   out_valid  result valid (DONE state)
//   out_ready  downstream accepts result
//   sum        WIDTH-bit result
//   cout       final carry-out
//   busy       high while bits are being added
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ADD  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // Full-adder cell: returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic [1:0]       fa_s;
    logic [WIDTH-1:0] b_load_s;
    logic             c_load_s;

    assign fa_s = full_add(a_sh_r[0], b_sh_r[0], carry_r);

    // Operand preparation at the accept edge (subtract inverts b and forces carry 1).
    always_comb begin
        b_load_s = b;
        c_load_s = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load_s = ~b;
            c_load_s = 1'b1;
        end else begin
            b_load_s = b;
            c_load_s = cin;
        end
`endif
    end

    // Sequencer: capture, bit-serial add, then hold result until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b_load_s;
                        carry_r <= c_load_s;
                        res_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ADD;
                    end
                end
                ADD: begin
                    carry_r <= fa_s[1];
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_r   <= {fa_s[0], res_r[WIDTH-1:1]};
                    // Counter parks at the last bit rather than wrapping.
                    if (cnt_r == LAST_BIT) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // in_ready is also gated by rst so nothing is offered during reset.
    assign in_ready  = (state_r == IDLE) && !rst;
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == ADD);
    assign sum       = res_r;
    assign cout      = carry_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Reference: {cout, sum} of an unsigned add (or a + ~b + 1 for subtract).
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + 9'd1;
        else   return {1'b0, x} + {1'b0, y} + {8'd0, c};
    endfunction

    function automatic logic [W:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    // Waits (bounded) for in_ready, presents one operand set for one accept edge.
    task automatic accept_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                             input logic tc, input logic ts, output logic ok);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        ok = in_ready;
        if (ok) begin
            a = ta; b = tbv; cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
            sub = ts;
`endif
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            exp_q.push_back(model(ta, tbv, tc, ts));
        end
    endtask

    // Counts cycles until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        if (!out_valid) cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b, required 0 0 0 00 0",
                     in_ready, out_valid, busy, sum, cout);
        end
        rst = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic ok; int cyc; logic [W:0] e;
        out_ready = 1'b1;
        accept_op(8'h5A, 8'h3C, 1'b0, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_accept: in_ready never 1"); end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy: busy=%b in_ready=%b required 1 0", busy, in_ready);
        end
        wait_valid(cyc);
        checks++;
        if (cyc !== 8) begin failures++; $display("FAIL basic_latency: got %0d cycles required 8", cyc); end
        e = pop_exp();
        checks++;
        if ({cout, sum} !== e || e !== 9'h096) begin
            failures++;
            $display("FAIL basic_result: got cout=%b sum=%h required cout=0 sum=96", cout, sum);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_after_handshake: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_carry();
        logic [W-1:0] ta[2] = '{8'hFF, 8'hFF};
        logic [W-1:0] tbv[2] = '{8'h01, 8'hFF};
        logic         tc[2] = '{1'b0, 1'b1};
        logic [W:0]   req[2] = '{9'h100, 9'h1FF};
        logic ok; int cyc; logic [W:0] e;
        for (int i = 0; i < 2; i++) begin
            out_ready = 1'b1;
            accept_op(ta[i], tbv[i], tc[i], 1'b0, ok);
            wait_valid(cyc);
            e = pop_exp();
            checks++;
            if (!ok || cyc < 0 || {cout, sum} !== e || e !== req[i]) begin
                failures++;
                $display("FAIL carry_%0d: got cout=%b sum=%h required %h (ok=%b cyc=%0d)",
                         i, cout, sum, req[i], ok, cyc);
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic ok; int cyc; logic [W:0] e;
        out_ready = 1'b0;
        accept_op(8'h5A, 8'h3C, 1'b0, 1'b0, ok);
        wait_valid(cyc);
        checks++;
        if (!ok || cyc !== 8) begin failures++; $display("FAIL bp_first_valid: ok=%b cyc=%0d required 8", ok, cyc); end
        e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            a = 8'h11 + 8'(i); b = 8'h22; cin = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || {cout, sum} !== e || in_ready !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: out_valid=%b cout=%b sum=%h in_ready=%b busy=%b required 1 %h 0 0",
                         i, out_valid, cout, sum, in_ready, busy, e);
            end
        end
        in_valid = 1'b0;
        e = pop_exp();
        checks++;
        if ({cout, sum} !== e) begin
            failures++;
            $display("FAIL bp_result: got %h required %h", {cout, sum}, e);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_extra_op: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_add();
        logic ok; int cyc; int seen; logic [W:0] e;
        out_ready = 1'b1;
        accept_op(8'h12, 8'h34, 1'b0, 1'b0, ok);
        void'(exp_q.pop_back());
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (!ok || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midadd_reset: ok=%b out_valid=%b sum=%h cout=%b busy=%b in_ready=%b required 1 0 00 0 0 0",
                     ok, out_valid, sum, cout, busy, in_ready);
        end
        rst = 1'b0; #1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midadd_no_output: out_valid cycles=%0d in_ready=%b required 0 1", seen, in_ready);
        end
        accept_op(8'h01, 8'h02, 1'b0, 1'b0, ok);
        wait_valid(cyc);
        e = pop_exp();
        checks++;
        if (!ok || cyc !== 8 || {cout, sum} !== e || e !== 9'h003) begin
            failures++;
            $display("FAIL midadd_fresh_op: got cout=%b sum=%h cyc=%0d required 0 03 8", cout, sum, cyc);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic pre; int accepts; int got; int valid1_cyc; int acc2_cyc; logic [W:0] e;
        accepts = 0; got = 0; valid1_cyc = -1; acc2_cyc = -1;
        a = 8'h21; b = 8'h43; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 2; cyc++) begin
            pre = in_valid && in_ready;
            @(posedge clk); #1;
            if (pre) begin
                accepts++;
                exp_q.push_back(model(a, b, cin, 1'b0));
                if (accepts == 1) begin
                    a = 8'hC8; b = 8'h64; cin = 1'b1;
                end else begin
                    acc2_cyc = cyc;
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                if (got == 0) valid1_cyc = cyc;
                e = pop_exp();
                checks++;
                if ({cout, sum} !== e) begin
                    failures++;
                    $display("FAIL b2b_result_%0d: got %h required %h", got, {cout, sum}, e);
                end
                got++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (got !== 2 || accepts !== 2 || acc2_cyc !== valid1_cyc + 2) begin
            failures++;
            $display("FAIL b2b_ordering: results=%0d accepts=%0d accept2_cycle=%0d required 2 2 %0d",
                     got, accepts, acc2_cyc, valid1_cyc + 2);
        end
    endtask

    task automatic test_random();
        logic ok; int cyc; logic [W:0] e; logic [W-1:0] ra; logic [W-1:0] rb; logic rc; logic rs;
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            out_ready = 1'b1;
            accept_op(ra, rb, rc, rs, ok);
            wait_valid(cyc);
            e = pop_exp();
            checks++;
            if (!ok || cyc !== 8 || {cout, sum} !== e) begin
                failures++;
                $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got %h required %h cyc=%0d",
                         i, ra, rb, rc, rs, {cout, sum}, e, cyc);
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [W-1:0] ta[2] = '{8'h10, 8'h01};
        logic [W-1:0] tbv[2] = '{8'h01, 8'h02};
        logic [W:0]   req[2] = '{9'h10F, 9'h0FF};
        logic ok; int cyc; logic [W:0] e;
        for (int i = 0; i < 2; i++) begin
            out_ready = 1'b1;
            accept_op(ta[i], tbv[i], 1'b0, 1'b1, ok);
            wait_valid(cyc);
            e = pop_exp();
            checks++;
            if (!ok || cyc < 0 || {cout, sum} !== e || e !== req[i]) begin
                failures++;
                $display("FAIL sub_%0d: got cout=%b sum=%h required %h", i, cout, sum, req[i]);
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid_add();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
